// File: rtl/cram_stream_pkg.sv
// Shared defaults, FSM encoding and read-credit helper for the CRAM read streamer.
package cram_stream_pkg;

  localparam int DWIDTH_DEF = 40;
  localparam int AWIDTH_DEF = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // A read may issue only if every word it could produce still has a FIFO slot.
  function automatic logic read_credit_ok(input logic [1:0] occupancy,
                                          input logic       in_flight,
                                          input logic       pop);
    logic [2:0] pending;
    pending = {1'b0, occupancy} + {2'b00, in_flight} - {2'b00, pop};
    return (pending < 3'd2);
  endfunction

endpackage

// File: rtl/cram_rd_skid_fifo.sv
// Two-entry circular skid buffer; the head entry is presented combinationally.
module cram_rd_skid_fifo
  import cram_stream_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] head,
  output logic              empty,
  output logic [1:0]        count
);

  logic [DWIDTH-1:0] mem_q [2];
  logic [DWIDTH-1:0] mem_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_push, do_pop;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: only two entries, so storage is cleared too; this keeps data_out at 0 after reset.
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    head  = mem_q[rd_ptr_q];
    empty = (count_q == 2'd0);
    count = count_q;
  end

endmodule

// File: rtl/cram_read_streamer.sv
// Streams a contiguous CRAM region through a 2-entry skid FIFO to the swizzle stage.
// Defining CRAM_RD_PARITY_EN adds ram_rparity / parity_err read-parity checking.
module cram_read_streamer
  import cram_stream_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AWIDTH-1:0] start_addr,
  input  logic [AWIDTH:0]   num_words,
  output logic              ram_re,
  output logic [AWIDTH-1:0] ram_addr,
  input  logic [DWIDTH-1:0] ram_rdata,
`ifdef CRAM_RD_PARITY_EN
  input  logic              ram_rparity,
  output logic              parity_err,
`endif
  input  logic              stall,
  output logic [DWIDTH-1:0] data_out,
  output logic              data_valid,
  output logic              data_last,
  output logic              busy,
  output logic              done
);

  localparam logic [AWIDTH:0] CNT_ONE = (AWIDTH + 1)'(1);

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [AWIDTH:0]     rd_left_q, rd_left_d;
  logic [AWIDTH:0]     words_left_q, words_left_d;
  logic                inflight_q, inflight_d;

  logic                start_ok, issue, pop;
  logic [DWIDTH-1:0]   fifo_head;
  logic                fifo_empty;
  logic [1:0]          fifo_count;

  // Handshake terms; reset gates them so a mid-transfer reset stops traffic in its own cycle.
  always_comb begin
    start_ok = start && (state_q == ST_IDLE) && !reset;
    pop      = !fifo_empty && !stall && !reset;
    issue    = (state_q == ST_RUN) && !reset &&
               read_credit_ok(fifo_count, inflight_q, pop);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = (num_words != '0) ? ST_RUN : ST_FIN;
      ST_RUN:   if (issue && (rd_left_q == CNT_ONE)) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && (words_left_q == CNT_ONE)) state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_re     = issue;
    ram_addr   = addr_q;
    data_out   = fifo_head;
    data_valid = pop;
    data_last  = pop && (words_left_q == CNT_ONE);
    busy       = (state_q != ST_IDLE) && !reset;
    done       = (state_q == ST_FIN) && !reset;
  end

  // Read address / count tracking; the emit counter drives data_last and DRAIN exit.
  always_comb begin
    addr_d       = addr_q;
    rd_left_d    = rd_left_q;
    words_left_d = words_left_q;
    inflight_d   = issue;
    if (start_ok) begin
      addr_d       = start_addr;
      rd_left_d    = num_words;
      words_left_d = num_words;
    end else begin
      if (issue) begin
        addr_d    = addr_q + AWIDTH'(1);
        rd_left_d = rd_left_q - CNT_ONE;
      end
      if (pop) begin
        words_left_d = words_left_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      rd_left_q    <= '0;
      words_left_q <= '0;
      inflight_q   <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      rd_left_q    <= rd_left_d;
      words_left_q <= words_left_d;
      inflight_q   <= inflight_d;
    end
  end

  cram_rd_skid_fifo #(
    .DWIDTH (DWIDTH)
  ) u_skid_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_q),
    .push_data (ram_rdata),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef CRAM_RD_PARITY_EN
  logic parity_err_q, parity_err_d;

  always_comb begin
    parity_err_d = parity_err_q;
    if (start_ok) begin
      parity_err_d = 1'b0;
    end else if (inflight_q && ((^ram_rdata) != ram_rparity)) begin
      parity_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) parity_err_q <= 1'b0;
    else       parity_err_q <= parity_err_d;
  end

  always_comb parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_cram_read_streamer.sv
// Directed bench for cram_read_streamer; define CRAM_RD_PARITY_EN to also exercise parity.
module tb_cram_read_streamer;

  localparam int DW = 40;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset, start, stall;
  logic [AW-1:0] start_addr;
  logic [AW:0]   num_words;
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] data_out;
  logic          data_valid, data_last, busy, done;
`ifdef CRAM_RD_PARITY_EN
  logic          ram_rparity, parity_err;
  logic          corrupt_en;
  logic [AW-1:0] corrupt_addr;
`endif

  int checks   = 0;
  int failures = 0;

  int            re_cyc[$];
  logic [AW-1:0] re_addr[$];
  int            dv_cyc[$];
  logic [DW-1:0] dv_data[$];
  logic          dv_last[$];
  int            done_cyc[$];
  logic [DW-1:0] stall_data[$];
  int            stall_idx[$];
  int            busy_cnt, busy_first, last_bad;

  always #5 clk = ~clk;

  cram_read_streamer #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .num_words  (num_words),
    .ram_re     (ram_re),
    .ram_addr   (ram_addr),
    .ram_rdata  (ram_rdata),
`ifdef CRAM_RD_PARITY_EN
    .ram_rparity(ram_rparity),
    .parity_err (parity_err),
`endif
    .stall      (stall),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_last  (data_last),
    .busy       (busy),
    .done       (done)
  );

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {4'hC, 27'(a) * 27'd7 + 27'd13, a};
  endfunction

  // CRAM model: one-cycle read latency, all-ones when not reading.
  always @(posedge clk) begin
    if (ram_re) ram_rdata <= word_of(ram_addr);
    else        ram_rdata <= '1;
`ifdef CRAM_RD_PARITY_EN
    ram_rparity <= ram_re ? ((^word_of(ram_addr)) ^ (corrupt_en && (ram_addr == corrupt_addr))) : 1'b0;
`endif
  end

  // Launches one transfer and records every DUT event; leaves the caller #1 after a posedge.
  task automatic run_xfer(input logic [AW-1:0] sa, input logic [AW:0] nw,
                          input int s1_word, input int s1_len,
                          input int s2_word, input int s2_len,
                          input int restart_cyc, input int max_cyc);
    int cyc, s1_used, s2_used, tail;
    re_cyc.delete(); re_addr.delete(); dv_cyc.delete(); dv_data.delete(); dv_last.delete();
    done_cyc.delete(); stall_data.delete(); stall_idx.delete();
    busy_cnt = 0; busy_first = -1; last_bad = 0;
    s1_used = 0; s2_used = 0; tail = 0;
    start = 1'b1; start_addr = sa; num_words = nw; stall = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    start_addr = ~sa; num_words = nw + 10'd7;
    cyc = 1;
    while (tail < 3 && cyc <= max_cyc) begin
      start = (cyc == restart_cyc);
      if (cyc == restart_cyc) begin start_addr = '0; num_words = 10'd3; end
      stall = 1'b0;
      if (dv_data.size() == s1_word - 1 && s1_used < s1_len) begin stall = 1'b1; s1_used++; end
      else if (dv_data.size() == s2_word - 1 && s2_used < s2_len) begin stall = 1'b1; s2_used++; end
      @(negedge clk);
      if (ram_re) begin re_cyc.push_back(cyc); re_addr.push_back(ram_addr); end
      if (data_valid) begin
        dv_cyc.push_back(cyc); dv_data.push_back(data_out); dv_last.push_back(data_last);
      end
      if (data_last && !data_valid) last_bad++;
      if (stall) begin stall_data.push_back(data_out); stall_idx.push_back(dv_data.size()); end
      if (busy) begin busy_cnt++; if (busy_first < 0) busy_first = cyc; end
      if (done) done_cyc.push_back(cyc);
      if (done_cyc.size() > 0) tail++;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; stall = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stall = 1'b0; start_addr = '0; num_words = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (ram_re !== 1'b0 || data_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_held got re=%b dv=%b busy=%b done=%b exp all 0", ram_re, data_valid, busy, done); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (ram_re !== 1'b0) begin failures++; $display("FAIL reset_ram_re got=%b exp=0", ram_re); end
    checks++; if (data_valid !== 1'b0 || data_last !== 1'b0) begin
      failures++; $display("FAIL reset_dv got dv=%b last=%b exp 0 0", data_valid, data_last); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_busy_done got busy=%b done=%b exp 0 0", busy, done); end
    checks++; if (ram_addr !== '0) begin failures++; $display("FAIL reset_ram_addr got=%h exp=0", ram_addr); end
    checks++; if (data_out !== '0) begin failures++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
`ifdef CRAM_RD_PARITY_EN
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_parity_err got=%b exp=0", parity_err); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int bad;
    logic [AW-1:0] ea;
    run_xfer(9'h010, 10'd40, -1, 0, -1, 0, -1, 80);
    checks++; if (re_cyc.size() != 40) begin failures++; $display("FAIL basic_re_count got=%0d exp=40", re_cyc.size()); end
    bad = 0;
    for (int i = 0; i < re_cyc.size(); i++) begin
      ea = 9'h010 + AW'(i);
      if (re_addr[i] !== ea || re_cyc[i] != i + 1) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL basic_re_seq got=%0d bad reads exp=0", bad); end
    checks++; if (dv_cyc.size() != 40) begin failures++; $display("FAIL basic_dv_count got=%0d exp=40", dv_cyc.size()); end
    bad = 0;
    for (int i = 0; i < dv_cyc.size(); i++) begin
      ea = 9'h010 + AW'(i);
      if (dv_data[i] !== word_of(ea) || dv_cyc[i] != i + 3 || dv_last[i] !== (i == 39)) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL basic_dv_seq got=%0d bad words exp=0", bad); end
    checks++; if (last_bad != 0) begin failures++; $display("FAIL basic_last_qual got=%0d exp=0", last_bad); end
    checks++; if (done_cyc.size() != 1 || done_cyc[0] != 43) begin
      failures++; $display("FAIL basic_done got n=%0d first=%0d exp n=1 cyc=43", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1); end
    checks++; if (busy_first != 1 || busy_cnt != 43) begin
      failures++; $display("FAIL basic_busy got first=%0d cnt=%0d exp first=1 cnt=43", busy_first, busy_cnt); end
  endtask

  task automatic test_wrap();
    int bad;
    logic [AW-1:0] exp_a [4];
    exp_a[0] = 9'h1FE; exp_a[1] = 9'h1FF; exp_a[2] = 9'h000; exp_a[3] = 9'h001;
    run_xfer(9'h1FE, 10'd4, -1, 0, -1, 0, -1, 30);
    checks++; if (re_addr.size() != 4) begin failures++; $display("FAIL wrap_re_count got=%0d exp=4", re_addr.size()); end
    bad = 0;
    for (int i = 0; i < 4 && i < re_addr.size(); i++) if (re_addr[i] !== exp_a[i]) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL wrap_addr got=%0d bad exp=0", bad); end
    bad = 0;
    for (int i = 0; i < 4 && i < dv_data.size(); i++) if (dv_data[i] !== word_of(exp_a[i])) bad++;
    checks++; if (bad != 0 || dv_data.size() != 4) begin
      failures++; $display("FAIL wrap_data got bad=%0d n=%0d exp bad=0 n=4", bad, dv_data.size()); end
    checks++; if (done_cyc.size() != 1 || done_cyc[0] != 7) begin
      failures++; $display("FAIL wrap_done got n=%0d exp n=1 cyc=7", done_cyc.size()); end
  endtask

  task automatic test_stall();
    int bad;
    logic [AW-1:0] ea;
    run_xfer(9'h0A0, 10'd80, 10, 3, 40, 1, -1, 200);
    checks++; if (dv_data.size() != 80) begin failures++; $display("FAIL stall_dv_count got=%0d exp=80", dv_data.size()); end
    bad = 0;
    for (int i = 0; i < dv_data.size(); i++) begin
      ea = 9'h0A0 + AW'(i);
      if (dv_data[i] !== word_of(ea) || dv_last[i] !== (i == 79)) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL stall_order got=%0d bad words exp=0", bad); end
    bad = 0;
    for (int i = 0; i < stall_data.size(); i++) begin
      ea = 9'h0A0 + AW'(stall_idx[i]);
      if (stall_data[i] !== word_of(ea)) bad++;
    end
    checks++; if (bad != 0 || stall_data.size() != 4) begin
      failures++; $display("FAIL stall_hold got bad=%0d n=%0d exp bad=0 n=4", bad, stall_data.size()); end
    checks++; if (done_cyc.size() != 1 || done_cyc[0] != 87) begin
      failures++; $display("FAIL stall_done got n=%0d first=%0d exp n=1 cyc=87", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1); end
    checks++; if (re_cyc.size() != 80) begin failures++; $display("FAIL stall_re_count got=%0d exp=80", re_cyc.size()); end
  endtask

  task automatic test_zero_and_busy();
    int bad;
    logic [AW-1:0] ea;
    run_xfer(9'h055, 10'd0, -1, 0, -1, 0, -1, 10);
    checks++; if (re_cyc.size() != 0 || dv_cyc.size() != 0) begin
      failures++; $display("FAIL zero_traffic got re=%0d dv=%0d exp 0 0", re_cyc.size(), dv_cyc.size()); end
    checks++; if (done_cyc.size() != 1 || done_cyc[0] != 1) begin
      failures++; $display("FAIL zero_done got n=%0d first=%0d exp n=1 cyc=1", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1); end
    run_xfer(9'h100, 10'd8, -1, 0, -1, 0, 4, 40);
    bad = 0;
    for (int i = 0; i < re_addr.size(); i++) begin
      ea = 9'h100 + AW'(i);
      if (re_addr[i] !== ea) bad++;
    end
    checks++; if (bad != 0 || re_addr.size() != 8) begin
      failures++; $display("FAIL busy_start_reads got bad=%0d n=%0d exp bad=0 n=8", bad, re_addr.size()); end
    bad = 0;
    for (int i = 0; i < dv_data.size(); i++) begin
      ea = 9'h100 + AW'(i);
      if (dv_data[i] !== word_of(ea)) bad++;
    end
    checks++; if (bad != 0 || dv_data.size() != 8) begin
      failures++; $display("FAIL busy_start_words got bad=%0d n=%0d exp bad=0 n=8", bad, dv_data.size()); end
    checks++; if (done_cyc.size() != 1 || done_cyc[0] != 11) begin
      failures++; $display("FAIL busy_start_done got n=%0d exp n=1 cyc=11", done_cyc.size()); end
  endtask

  task automatic test_reset_mid();
    int n, guard, stray;
    logic [AW-1:0] ea;
    int bad;
    start = 1'b1; start_addr = 9'h040; num_words = 10'd40; stall = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; guard = 0;
    while (n < 20 && guard < 100) begin
      @(negedge clk);
      if (data_valid) n++;
      @(posedge clk); #1;
      guard++;
    end
    checks++; if (n != 20) begin failures++; $display("FAIL rstmid_reach got=%0d exp=20", n); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (data_valid !== 1'b0 || ram_re !== 1'b0) begin
      failures++; $display("FAIL rstmid_same_cycle got dv=%b re=%b exp 0 0", data_valid, ram_re); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (data_valid !== 1'b0 || busy !== 1'b0 || ram_re !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL rstmid_after got dv=%b busy=%b re=%b done=%b exp all 0", data_valid, busy, ram_re, done); end
    stray = 0;
    repeat (5) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (data_valid || ram_re || busy || done) stray++;
    end
    @(posedge clk); #1;
    checks++; if (stray != 0) begin failures++; $display("FAIL rstmid_quiet got=%0d active cycles exp=0", stray); end
    run_xfer(9'h080, 10'd5, -1, 0, -1, 0, -1, 30);
    bad = 0;
    for (int i = 0; i < dv_data.size(); i++) begin
      ea = 9'h080 + AW'(i);
      if (dv_data[i] !== word_of(ea) || dv_cyc[i] != i + 3) bad++;
    end
    checks++; if (bad != 0 || dv_data.size() != 5) begin
      failures++; $display("FAIL rstmid_restart got bad=%0d n=%0d exp bad=0 n=5", bad, dv_data.size()); end
    checks++; if (done_cyc.size() != 1 || done_cyc[0] != 8) begin
      failures++; $display("FAIL rstmid_restart_done got n=%0d exp n=1 cyc=8", done_cyc.size()); end
  endtask

`ifdef CRAM_RD_PARITY_EN
  task automatic test_parity();
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL parity_clean got=%b exp=0", parity_err); end
    corrupt_en = 1'b1; corrupt_addr = 9'h024;
    run_xfer(9'h020, 10'd8, -1, 0, -1, 0, -1, 30);
    corrupt_en = 1'b0;
    checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL parity_set got=%b exp=1", parity_err); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL parity_sticky got=%b exp=1", parity_err); end
    run_xfer(9'h030, 10'd4, -1, 0, -1, 0, -1, 30);
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL parity_clear got=%b exp=0", parity_err); end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; start_addr = '0; num_words = '0;
`ifdef CRAM_RD_PARITY_EN
    corrupt_en = 1'b0; corrupt_addr = '0;
`endif
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_zero_and_busy();
    test_reset_mid();
`ifdef CRAM_RD_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cram_read_streamer.md
CRAM_READ_STREAMER -- requirements
Module: cram_read_streamer

Interface
REQ-001 SHALL have parameter DWIDTH, default 40: CRAM port data width.
REQ-002 SHALL have parameter AWIDTH, default 9: CRAM port address width.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle pulse that launches a transfer.
REQ-006 SHALL have port start_addr, input, AWIDTH: first CRAM word address.
REQ-007 SHALL have port num_words, input, AWIDTH+1: word count, 0..2^AWIDTH.
REQ-008 SHALL have port ram_re, output, 1: CRAM read enable.
REQ-009 SHALL have port ram_addr, output, AWIDTH: CRAM read address.
REQ-010 SHALL have port ram_rdata, input, DWIDTH: CRAM read data, valid exactly 1 cycle after ram_re.
REQ-011 SHALL have port stall, input, 1: downstream hold request.
REQ-012 SHALL have port data_out, output, DWIDTH: streamed word to the swizzle stage.
REQ-013 SHALL have port data_valid, output, 1: data_out carries a word this cycle.
REQ-014 SHALL have port data_last, output, 1: qualifies the final word; high only with data_valid.
REQ-015 SHALL have port busy, output, 1: transfer in progress.
REQ-016 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-017 SHALL implement FSM IDLE -> RUN -> DRAIN -> FIN -> IDLE.
- IDLE -> RUN on start with num_words>0.
- RUN -> DRAIN when the last read is issued.
- DRAIN -> FIN when the last word is emitted.
- FIN -> IDLE unconditionally.
REQ-018 SHALL latch start_addr and num_words on start; later changes to these inputs have no effect.
REQ-019 SHALL ignore start while busy=1.
REQ-020 SHALL treat start with num_words=0 as a no-op: no ram_re, no data_valid, done pulses the next cycle.
REQ-021 SHALL buffer read data in a 2-entry skid FIFO whose head drives data_out.
REQ-022 SHALL issue a read only when (FIFO occupancy + reads in flight - pop this cycle) < 2.
REQ-023 SHALL increment ram_addr by 1 per issued read, wrapping modulo 2^AWIDTH (for example 511 -> 0).
REQ-024 SHALL define data_valid = FIFO non-empty AND NOT stall; each data_valid cycle pops one word.
REQ-025 SHALL hold data_out stable across stall cycles, never drop or duplicate a word, and never overflow the FIFO.
REQ-026 SHALL have latency with stall=0 of: start sampled at cycle 0, first ram_re at cycle 1, first data_valid at cycle 3, then one word per cycle back-to-back.
REQ-027 SHALL assert data_last on the num_words-th emitted word only.
REQ-028 SHALL assert busy from the cycle after start through the done cycle inclusive.
REQ-029 SHALL pulse done in the cycle after the data_last word is emitted.

Reset
REQ-030 SHALL on reset force the FSM to IDLE, flush the FIFO, and discard any in-flight read.
REQ-031 SHALL on reset drive ram_re, data_valid, data_last, busy and done to 0, and ram_addr and data_out to 0.
REQ-032 SHALL apply reset mid-transfer in the same cycle, with no further ram_re or data_valid until a new start.

Configuration
REQ-033 SHALL, with CRAM_RD_PARITY_EN defined:
- add input ram_rparity (1 bit, same timing as ram_rdata);
- add output parity_err (1 bit), sticky, set when ^ram_rdata != ram_rparity on any returned word;
- clear parity_err on reset or on an accepted start.
REQ-034 SHALL, without CRAM_RD_PARITY_EN, omit both ports and all parity logic.

Structure
REQ-035 SHALL place the DWIDTH/AWIDTH defaults and the FSM state encoding in shared package cram_stream_pkg.
REQ-036 SHALL implement the 2-entry skid FIFO as sub-module cram_rd_skid_fifo.

Verification
REQ-037 SHALL cover: start_addr=0x010, num_words=40, stall=0 -> ram_addr 0x010..0x037; 40 consecutive data_valid from cycle 3; data_last on word 40; done at cycle 43.
REQ-038 SHALL cover: start_addr=0x1FE, num_words=4 -> reads at 0x1FE, 0x1FF, 0x000, 0x001; words emitted in that order.
REQ-039 SHALL cover: num_words=80 with stall high for 3 cycles at word 10 and 1 cycle at word 40 -> all 80 words in order, no loss or duplication, data_out stable during stall.
REQ-040 SHALL cover: num_words=0 -> no ram_re, no data_valid, done one cycle after start; and a start pulse during busy -> ignored.
REQ-041 SHALL cover: reset asserted at word 20 of 40 -> next cycle data_valid=0, busy=0, ram_re=0; a new start then runs cleanly.
REQ-042 SHALL cover, with CRAM_RD_PARITY_EN: corrupt the parity of word 5 -> parity_err=1 and held until the next start.
